// File: rtl/key_multi_accum_led.sv
// Key-driven multi-operand calculator: two debounced push-keys enter NUM_OPS operands,
// then the LEDs show their sum, difference, XOR or maximum as selected by mode.
module key_multi_accum_led #(
  parameter int WIDTH        = 2,
  parameter int NUM_OPS      = 2,
  parameter int DEBOUNCE_CYC = 500000,
  localparam int OUT_W       = WIDTH + $clog2(NUM_OPS),
  localparam int SIDX_W      = $clog2(NUM_OPS + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key_next,
  input  logic              key_inc,
  input  logic [1:0]        mode,
  output logic [OUT_W-1:0]  led,
  output logic [SIDX_W-1:0] state_idx,
  output logic              result_valid
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [SIDX_W-1:0] ST_RESULT  = SIDX_W'(NUM_OPS);
  localparam logic [SIDX_W-1:0] ST_LAST_OP = SIDX_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    MODE_SUM  = 2'b00,
    MODE_DIFF = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_MAX  = 2'b11
  } mode_e;

  // Key path: index 0 is key_next, index 1 is key_inc (both active-low).
  logic [1:0]       keys_raw;
  logic [1:0]       sync1_q, sync2_q, deb_q, press_q;
  logic [CNT_W-1:0] cnt_q [2];

  assign keys_raw = {key_inc, key_next};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_q[i]   <= '0;
          deb_q[i]   <= sync2_q[i];
          press_q[i] <= ~sync2_q[i];  // pulse only on the 1->0 (press) flip
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic next_evt, inc_evt;
  assign next_evt = press_q[0];
  assign inc_evt  = press_q[1] & ~press_q[0];

  logic [SIDX_W-1:0] state_q, state_d;
  logic              valid_q;
  logic [WIDTH-1:0]  ops_q [NUM_OPS];
  logic [WIDTH-1:0]  ops_d [NUM_OPS];
  mode_e             mode_q, mode_d;
  logic [OUT_W-1:0]  led_q, led_d;

  // NOTE: the operand array is reset explicitly because it is architectural state
  // the user sees; it is small, so there is no reason to leave it unreset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= '0;
      valid_q <= 1'b0;
      mode_q  <= MODE_SUM;
      led_q   <= '0;
      for (int k = 0; k < NUM_OPS; k++) ops_q[k] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == ST_RESULT);
      mode_q  <= mode_d;
      led_q   <= led_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (next_evt) state_d = (state_q == ST_RESULT) ? '0 : state_q + 1'b1;
  end

  always_comb begin
    ops_d  = ops_q;
    mode_d = mode_q;
    if (next_evt && state_q == ST_LAST_OP) mode_d = mode_e'(mode);
    if (inc_evt) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (state_q == ST_RESULT)          ops_d[k] = '0;
        else if (state_q == SIDX_W'(k))    ops_d[k] = ops_q[k] + 1'b1;
      end
    end
  end

  // Result candidates are computed from the registered operands every cycle.
  logic [OUT_W-1:0] rest_sum, res_sum, res_diff;
  logic [WIDTH-1:0] res_xor, res_max;

  always_comb begin
    rest_sum = '0;
    res_xor  = ops_q[0];
    res_max  = ops_q[0];
    for (int k = 1; k < NUM_OPS; k++) begin
      rest_sum = rest_sum + OUT_W'(ops_q[k]);
      res_xor  = res_xor ^ ops_q[k];
      if (ops_q[k] > res_max) res_max = ops_q[k];
    end
    res_sum  = OUT_W'(ops_q[0]) + rest_sum;
    res_diff = OUT_W'(ops_q[0]) - rest_sum;
  end

  always_comb begin
    led_d = '0;
    if (state_q == ST_RESULT) begin
      unique case (mode_q)
        MODE_SUM:  led_d = res_sum;
        MODE_DIFF: led_d = res_diff;
        MODE_XOR:  led_d = OUT_W'(res_xor);
        MODE_MAX:  led_d = OUT_W'(res_max);
        default:   led_d = '0;
      endcase
    end else begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (state_q == SIDX_W'(k)) led_d = OUT_W'(ops_q[k]);
      end
    end
  end

  assign led          = led_q;
  assign state_idx    = state_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_key_multi_accum_led.sv
// Scenario bench for key_multi_accum_led with a short debounce; expected
// {led, state_idx, result_valid} triples are queued and popped for comparison.
module tb_key_multi_accum_led;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_next = 1'b1;
  logic       key_inc = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [2:0] led;
  logic [1:0] state_idx;
  logic       result_valid;

  key_multi_accum_led #(.WIDTH(2), .NUM_OPS(2), .DEBOUNCE_CYC(4)) dut (
    .sys_clk      (clk),
    .sys_rst      (sys_rst),
    .key_next     (key_next),
    .key_inc      (key_inc),
    .mode         (mode),
    .led          (led),
    .state_idx    (state_idx),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] val;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [5:0] obs;
  assign obs = {led, state_idx, result_valid};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_inc();
    key_inc = 1'b0; tick(8);
    key_inc = 1'b1; tick(8);
  endtask

  task automatic press_next();
    key_next = 1'b0; tick(8);
    key_next = 1'b1; tick(8);
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; tick(3);
    sys_rst = 1'b0; tick(1);
  endtask

  task automatic test_reset();
    key_next = 1'b0;
    sys_rst  = 1'b1; tick(3);
    sys_rst  = 1'b0;
    sb.push_back('{"reset_values", {3'd0, 2'd0, 1'b0}});
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    sb.push_back('{"held_key_no_early_event", {3'd0, 2'd0, 1'b0}});
    tick(4);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    sb.push_back('{"held_key_debounced_again", {3'd0, 2'd1, 1'b0}});
    tick(10);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    key_next = 1'b1; tick(10);
    apply_reset();
  endtask

  task automatic test_sum();
    bit found = 1'b0;
    mode = 2'b00;
    repeat (3) press_inc();
    press_next();
    repeat (2) press_inc();
    sb.push_back('{"result_entry", {3'd2, 2'd2, 1'b1}});
    sb.push_back('{"sum_one_cycle_after_entry", {3'd5, 2'd2, 1'b1}});
    sb.push_back('{"sum_hold", {3'd5, 2'd2, 1'b1}});
    key_next = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (state_idx == 2'd2) found = 1'b1;
    end
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    key_next = 1'b1; tick(10);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_wrap();
    apply_reset();
    sb.push_back('{"wrap_5_inc", {3'd1, 2'd0, 1'b0}});
    repeat (5) press_inc();
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    sb.push_back('{"glitch_ignored", {3'd1, 2'd0, 1'b0}});
    key_inc = 1'b0; tick(2);
    key_inc = 1'b1; tick(10);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    sb.push_back('{"long_hold_one_inc", {3'd2, 2'd0, 1'b0}});
    key_inc = 1'b0; tick(20);
    key_inc = 1'b1; tick(10);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_modes();
    logic [2:0] mexp [3] = '{3'd7, 3'd3, 3'd2};
    for (int m = 1; m <= 3; m++) begin
      apply_reset();
      press_inc();
      press_next();
      repeat (2) press_inc();
      mode = 2'(m);
      sb.push_back('{$sformatf("mode_%0d_result", m), {mexp[m-1], 2'd2, 1'b1}});
      press_next();
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    end
    sb.push_back('{"mode_change_ignored", {3'd2, 2'd2, 1'b1}});
    mode = 2'b00; tick(5);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_clear();
    bit found = 1'b0;
    sb.push_back('{"clear_in_result", {3'd0, 2'd2, 1'b1}});
    key_inc = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (led == 3'd0) found = 1'b1;
    end
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    key_inc = 1'b1; tick(10);
    sb.push_back('{"result_next_to_enter0", {3'd0, 2'd0, 1'b0}});
    press_next();
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    press_inc();
    sb.push_back('{"simultaneous_next_wins", {3'd0, 2'd1, 1'b0}});
    key_next = 1'b0; key_inc = 1'b0; tick(8);
    key_next = 1'b1; key_inc = 1'b1; tick(8);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    mode = 2'b00;
    sb.push_back('{"op0_unchanged_sum", {3'd1, 2'd2, 1'b1}});
    press_next();
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    sb.push_back('{"reset_in_result", {3'd0, 2'd0, 1'b0}});
    sb.push_back('{"post_reset_idle", {3'd0, 2'd0, 1'b0}});
    sys_rst = 1'b1; tick(1);
    sys_rst = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    tick(3);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_sum();
    test_wrap();
    test_modes();
    test_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
